// File: rtl/inpkt_parser.sv
// inpkt_parser
// Pops 16-bit words from a first-word-fall-through input FIFO and checks a
// 4-word packet header. It then writes the payload to a downstream byte FIFO,
// low byte first, verifies the trailing checksum word and reports completion
// and sticky errors.
//
// Ports
//   CLK          single clock
//   rst_n        asynchronous active-low reset
//   din[15:0]    input FIFO head word (valid while !empty)
//   empty        input FIFO empty
//   rd_en        pop strobe to the input FIFO (combinational)
//   dout[7:0]    payload byte, combinational mux of din
//   wr_en        byte strobe to the downstream FIFO (combinational)
//   full         downstream FIFO full
//   pkt_end      qualifies wr_en on the last payload byte
//   pkt_type     type of the current packet (registered)
//   pkt_id       id of the current packet (registered)
//   pkt_done     1-cycle pulse after a matching checksum pop
//   err_hdr      sticky header error
//   err_checksum sticky checksum error
//
// state   | meaning
// --------+---------------------------------------------------------------
// HDR0    | wait for w0, check version and type
// HDR1    | wait for w1, capture len[15:0]
// HDR2    | wait for w2, check reserved byte and the assembled length
// HDR3    | wait for w3, capture id, clear byte count and sum
// DATA_LO | emit din[7:0]; pop only when it is the last byte
// DATA_HI | emit din[15:8] and pop (head word already present)
// CSUM    | pop checksum word, compare with ~sum
// ERROR   | framing lost, frozen until reset
module inpkt_parser #(
  parameter int PKT_VERSION = 2,
  parameter int PKT_MAX_LEN = 65536
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        empty,
  output logic        rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic        pkt_end,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic        pkt_done,
  output logic        err_hdr,
  output logic        err_checksum
);

  localparam logic [2:0] S_HDR0    = 3'd0;
  localparam logic [2:0] S_HDR1    = 3'd1;
  localparam logic [2:0] S_HDR2    = 3'd2;
  localparam logic [2:0] S_HDR3    = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_DATA_HI = 3'd5;
  localparam logic [2:0] S_CSUM    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  localparam logic [7:0]  VERSION = 8'(PKT_VERSION);
  localparam logic [23:0] MAX_LEN = 24'(PKT_MAX_LEN);

  logic [2:0]  state;
  logic [15:0] len_lo;
  logic [23:0] len;
  logic [23:0] byte_cnt;
  logic [15:0] sum;

  logic [23:0] cnt_inc;
  logic        last_byte;
  logic [23:0] hdr_len;
  logic        hdr2_bad;

  assign cnt_inc   = byte_cnt + 24'd1;
  assign last_byte = (cnt_inc == len);
  assign hdr_len   = {din[7:0], len_lo};
  assign hdr2_bad  = (din[15:8] != 8'h00) || (hdr_len == 24'd0) || (hdr_len > MAX_LEN);

  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    pkt_end = 1'b0;
    dout    = din[7:0];
    case (state)
      S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_CSUM: begin
        rd_en = !empty;
      end
      S_DATA_LO: begin
        if (!empty && !full) begin
          wr_en = 1'b1;
          if (last_byte) begin
            rd_en   = 1'b1;
            pkt_end = 1'b1;
          end
        end
      end
      S_DATA_HI: begin
        if (!full) begin
          wr_en   = 1'b1;
          dout    = din[15:8];
          rd_en   = 1'b1;
          pkt_end = last_byte;
        end
      end
      default: ;
    endcase
    // Strobes must read zero while reset is held, not just after the next edge.
    if (!rst_n) begin
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      pkt_end = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_HDR0;
      len_lo       <= 16'h0000;
      len          <= 24'h000000;
      byte_cnt     <= 24'h000000;
      sum          <= 16'h0000;
      pkt_type     <= 8'h00;
      pkt_id       <= 16'h0000;
      pkt_done     <= 1'b0;
      err_hdr      <= 1'b0;
      err_checksum <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        S_HDR0: begin
          if (!empty) begin
            pkt_type <= din[15:8];
            if ((din[7:0] != VERSION) || (din[15:8] == 8'h00)) begin
              err_hdr <= 1'b1;
              state   <= S_ERROR;
            end else begin
              state <= S_HDR1;
            end
          end
        end
        S_HDR1: begin
          if (!empty) begin
            len_lo <= din;
            state  <= S_HDR2;
          end
        end
        S_HDR2: begin
          if (!empty) begin
            if (hdr2_bad) begin
              err_hdr <= 1'b1;
              state   <= S_ERROR;
            end else begin
              len   <= hdr_len;
              state <= S_HDR3;
            end
          end
        end
        S_HDR3: begin
          if (!empty) begin
            pkt_id   <= din;
            byte_cnt <= 24'h000000;
            sum      <= 16'h0000;
            state    <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (!empty && !full) begin
            byte_cnt <= cnt_inc;
            if (last_byte) begin
              // Odd length: the high byte of this word is padding, still summed.
              sum   <= sum + din;
              state <= S_CSUM;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (!full) begin
            byte_cnt <= cnt_inc;
            sum      <= sum + din;
            state    <= last_byte ? S_CSUM : S_DATA_LO;
          end
        end
        S_CSUM: begin
          if (!empty) begin
            if (din == ~sum) begin
              pkt_done <= 1'b1;
              state    <= S_HDR0;
            end else begin
              err_checksum <= 1'b1;
              state        <= S_ERROR;
            end
          end
        end
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_inpkt_parser.sv
// Directed bench for inpkt_parser: behavioural FWFT input FIFO and byte sink,
// expected bytes and checksums computed from the packet contents.
module tb_inpkt_parser;
  localparam int PKT_VERSION = 2;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        empty = 1'b1;
  logic        full = 1'b0;
  logic        rd_en, wr_en, pkt_end, pkt_done, err_hdr, err_checksum;
  logic [7:0]  dout, pkt_type;
  logic [15:0] pkt_id;

  inpkt_parser #(.PKT_VERSION(PKT_VERSION), .PKT_MAX_LEN(65536)) dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .empty(empty), .rd_en(rd_en),
    .dout(dout), .wr_en(wr_en), .full(full), .pkt_end(pkt_end),
    .pkt_type(pkt_type), .pkt_id(pkt_id), .pkt_done(pkt_done),
    .err_hdr(err_hdr), .err_checksum(err_checksum)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  logic [7:0]  pay[$];
  logic [7:0]  exp_b[$];
  int          exp_ends[$];
  logic [7:0]  rx[$];
  int          ends[$];
  int          pop_cyc[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1;
  int viol_full = 0, viol_empty = 0, viol_end = 0, underflow = 0;
  int p_full = 0, p_empty = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, expv);
    end
  endtask

  // Drive FIFO head at the falling edge, sample strobes just before the rise.
  initial begin
    int qs;
    forever begin
      @(negedge CLK);
      qs    = q.size();
      empty = (qs == 0) || ($urandom_range(99) < p_empty);
      full  = ($urandom_range(99) < p_full);
      din   = (qs != 0) ? q[0] : 16'h0000;
      #4;
      cyc++;
      if (pkt_done) begin done_cnt++; done_cyc = cyc; end
      if (wr_en) begin
        if (full) viol_full++;
        rx.push_back(dout);
        if (pkt_end) ends.push_back(rx.size() - 1);
      end else if (pkt_end) viol_end++;
      if (rd_en) begin
        if (empty && !wr_en) viol_empty++;
        if (qs == 0) underflow++;
        else begin
          void'(q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic int pc(input int i);
    return (pop_cyc.size() > i) ? pop_cyc[i] : -1000;
  endfunction

  task automatic clear_log();
    q.delete(); pay.delete(); exp_b.delete(); exp_ends.delete();
    rx.delete(); ends.delete(); pop_cyc.delete();
    done_cnt = 0; done_cyc = -1; viol_full = 0; viol_empty = 0;
    viol_end = 0; underflow = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    #2 clear_log();
    @(negedge CLK); #2;
    rst_n = 1'b1;
  endtask

  // Builds a packet from pay[], appends its words to the FIFO model and its
  // bytes to the expected stream. csum_delta corrupts the checksum word.
  task automatic push_pkt(input logic [7:0] typ, input logic [15:0] id,
                          input logic [7:0] pad, input logic [15:0] csum_delta);
    logic [23:0] l;
    logic [15:0] s, w;
    int n;
    n = pay.size();
    l = 24'(n);
    s = 16'h0000;
    q.push_back({typ, 8'(PKT_VERSION)});
    q.push_back(l[15:0]);
    q.push_back({8'h00, l[23:16]});
    q.push_back(id);
    for (int i = 0; i < n; i += 2) begin
      w[7:0]  = pay[i];
      w[15:8] = (i + 1 < n) ? pay[i + 1] : pad;
      s = s + w;
      q.push_back(w);
    end
    q.push_back((~s) + csum_delta);
    for (int i = 0; i < n; i++) exp_b.push_back(pay[i]);
    exp_ends.push_back(exp_b.size() - 1);
    pay.delete();
  endtask

  task automatic rand_pay(input int n);
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255)));
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(negedge CLK); n++; end
    check_val({tag, "_done_in_time"}, done_cnt, target);
    repeat (3) @(negedge CLK);
    #1;
  endtask

  task automatic check_stream(input string tag);
    int mism;
    mism = 0;
    check_val({tag, "_nbytes"}, rx.size(), exp_b.size());
    for (int i = 0; i < rx.size() && i < exp_b.size(); i++)
      if (rx[i] !== exp_b[i]) mism++;
    check_val({tag, "_byte_mism"}, mism, 0);
    mism = 0;
    check_val({tag, "_nends"}, ends.size(), exp_ends.size());
    for (int i = 0; i < ends.size() && i < exp_ends.size(); i++)
      if (ends[i] != exp_ends[i]) mism++;
    check_val({tag, "_end_pos"}, mism, 0);
  endtask

  logic [15:0] hw0[5] = '{16'h0103, 16'h0002, 16'h0102, 16'h0102, 16'h0102};
  logic [15:0] hw1[5] = '{16'h0004, 16'h0004, 16'h0000, 16'h0001, 16'h0004};
  logic [15:0] hw2[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0100};
  int          hpops[5] = '{1, 1, 3, 3, 3};

  initial begin
    // Reset state, with a word at the FIFO head so rd_en is meaningful.
    q.push_back(16'h5555);
    repeat (2) @(negedge CLK);
    #1;
    check_val("rst_empty_seen", empty, 0);
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_pkt_end", pkt_end, 0);
    check_val("rst_pkt_done", pkt_done, 0);
    check_val("rst_err", {err_hdr, err_checksum}, 0);
    check_val("rst_type_id", {pkt_type, pkt_id}, 0);
    check_val("rst_dout", dout, 8'h55);
    do_reset();

    // Valid packet, len 4: expect 9 cycles from first header pop to checksum pop.
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_pkt(8'h01, 16'h1234, 8'h00, 16'h0000);
    wait_done("p1", 1, 100);
    check_stream("p1");
    check_val("p1_pops", pop_cyc.size(), 7);
    check_val("p1_span", pc(6) - pc(0), 8);
    check_val("p1_done_lat", done_cyc - pc(6), 1);
    check_val("p1_done_cnt", done_cnt, 1);
    check_val("p1_type", pkt_type, 8'h01);
    check_val("p1_id", pkt_id, 16'h1234);
    check_val("p1_err", {err_hdr, err_checksum}, 0);

    // Odd length 3: words AA11, 0022 (high byte of the last word is padding).
    do_reset();
    pay = '{8'h11, 8'hAA, 8'h22};
    push_pkt(8'h02, 16'h0003, 8'h00, 16'h0000);
    wait_done("odd", 1, 100);
    check_stream("odd");
    check_val("odd_err", {err_hdr, err_checksum}, 0);

    // Back-to-back packets, no gap.
    do_reset();
    rand_pay(4);
    push_pkt(8'h05, 16'hBEEF, 8'h00, 16'h0000);
    rand_pay(6);
    push_pkt(8'h07, 16'hCAFE, 8'h00, 16'h0000);
    wait_done("b2b", 2, 200);
    check_stream("b2b");
    check_val("b2b_gap", pc(7) - pc(6), 1);
    check_val("b2b_id", pkt_id, 16'hCAFE);
    check_val("b2b_type", pkt_type, 8'h07);

    // Header errors, one per run.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      q.push_back(hw0[k]); q.push_back(hw1[k]); q.push_back(hw2[k]);
      q.push_back(16'h1111);
      for (int j = 0; j < 4; j++) q.push_back(16'h2200 + 16'(j));
      repeat (20) @(negedge CLK);
      #1;
      check_val($sformatf("hdr%0d_err_hdr", k), err_hdr, 1);
      check_val($sformatf("hdr%0d_err_cs", k), err_checksum, 0);
      check_val($sformatf("hdr%0d_wr", k), rx.size(), 0);
      check_val($sformatf("hdr%0d_pops", k), pop_cyc.size(), hpops[k]);
      check_val($sformatf("hdr%0d_rd_held", k), rd_en, 0);
    end

    // Checksum off by one, followed by a good packet that must not be parsed.
    do_reset();
    rand_pay(4);
    push_pkt(8'h03, 16'h0BAD, 8'h00, 16'h0001);
    rand_pay(2);
    push_pkt(8'h04, 16'h0600, 8'h00, 16'h0000);
    repeat (40) @(negedge CLK);
    #1;
    check_val("cs_nbytes", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++)
      check_val($sformatf("cs_byte%0d", i), rx[i], exp_b[i]);
    check_val("cs_err_cs", err_checksum, 1);
    check_val("cs_err_hdr", err_hdr, 0);
    check_val("cs_done", done_cnt, 0);
    check_val("cs_pops", pop_cyc.size(), 7);
    check_val("cs_rd_held", rd_en, 0);

    // Backpressure, len 255.
    do_reset();
    p_full = 50; p_empty = 30;
    rand_pay(255);
    push_pkt(8'h09, 16'h0255, 8'h5A, 16'h0000);
    wait_done("bp", 1, 5000);
    check_stream("bp");
    check_val("bp_no_wr_full", viol_full, 0);
    check_val("bp_no_pop_empty", viol_empty, 0);
    check_val("bp_underflow", underflow, 0);
    check_val("bp_end_no_wr", viol_end, 0);
    check_val("bp_err", {err_hdr, err_checksum}, 0);

    // Reset mid-payload, then resend.
    do_reset();
    rand_pay(255);
    push_pkt(8'h0A, 16'h0A0A, 8'h00, 16'h0000);
    begin
      int n;
      n = 0;
      while (rx.size() < 100 && n < 3000) begin @(negedge CLK); n++; end
    end
    check_val("mid_reached", rx.size() >= 100, 1);
    @(negedge CLK); #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_strobes", {rd_en, wr_en, pkt_end}, 0);
    check_val("mid_rst_type_id", {pkt_type, pkt_id}, 0);
    repeat (2) @(negedge CLK);
    #2 clear_log();
    @(negedge CLK); #2;
    rst_n = 1'b1;
    rand_pay(255);
    push_pkt(8'h0B, 16'h0B0B, 8'hC3, 16'h0000);
    wait_done("resend", 1, 5000);
    check_stream("resend");
    check_val("resend_id", pkt_id, 16'h0B0B);
    check_val("resend_no_wr_full", viol_full, 0);
    check_val("resend_err", {err_hdr, err_checksum}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d exp 0", 1);
    $fatal(1, "timeout");
  end
endmodule
